bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the single system data bus (RAM, GPIO, UART, I2C behind io_select) between two masters: m0 = cpu, m1 = DMA/secondary master.
- Bus outputs are muxed combinationally from the granted master in the same cycle.
- Read data returns one cycle after a granted read, with a valid strobe steered to the master that issued the read.
- Arbitration is round-robin with a bounded burst length, so neither master can starve the other.

Parameters:
- MAX_BURST, 4: maximum consecutive grants to one master while the other is requesting. Legal range 1..15; 1 gives strict alternation.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 bus request
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_mask  in  4  master 0 byte-enable mask
- m0_we  in  1  master 0 write enable
- m0_re  in  1  master 0 read enable
- m0_gnt  out  1  master 0 granted this cycle
- m0_rvalid  out  1  read data for master 0 valid this cycle
- m1_req, m1_addr, m1_wdata, m1_mask, m1_we, m1_re, m1_gnt, m1_rvalid: same as m0, for master 1
- bus_addr  out  32  shared bus address
- bus_wdata  out  32  shared bus write data
- bus_mask  out  4  shared bus byte mask
- bus_we  out  1  shared bus write enable
- bus_re  out  1  shared bus read enable
- bus_rdata  in  32  read data from data_src, one cycle after bus_re
- rdata  out  32  bus_rdata forwarded combinationally to both masters

Behaviour:
- State registers:
  - owner (1b): last granted master.
  - cnt: consecutive grants to owner, width $clog2(MAX_BURST+1), saturating at MAX_BURST.
  - rd_pend (1b) and rd_id (1b): outstanding read and which master issued it.
- Reset (synchronous, clk_sys edge with reset=1) sets owner=0, cnt=0, rd_pend=0. This holds even mid-read: the pending rvalid is dropped and never appears after reset.
- During reset, all gnt, rvalid, bus_we and bus_re outputs are 0.
- Winner selection (combinational):
  - Neither master requesting: no grant.
  - Exactly one requesting: that master wins.
  - Both requesting: winner = owner if cnt < MAX_BURST, otherwise the other master.
- Grant output: mX_gnt = 1 only for the winner. A grant is a complete single-cycle bus transaction.
- Request hold rule: a master keeps req and its signals stable until it sees gnt. It may drop req the cycle after gnt or issue a new request.
- Bus outputs:
  - While a master is granted, bus_* equal that master's signals.
  - With no grant, bus_addr, bus_wdata, bus_mask, bus_we and bus_re are all 0.
  - If the winner has we=1 and re=1, the write proceeds and bus_re is forced to 0; no rvalid follows.
- Register updates per cycle:
  - Grant to w == owner: cnt <= min(cnt+1, MAX_BURST).
  - Grant to w != owner: owner <= w, cnt <= 1.
  - Idle cycle (no grant): cnt <= 0, owner held.
- Read return:
  - A granted read (bus_re=1) sets rd_pend <= 1 and rd_id <= winner for the next cycle; otherwise rd_pend <= 0.
  - mX_rvalid = rd_pend & (rd_id == X).
  - rdata = bus_rdata, unconditionally.
- Back-to-back: a read in cycle N and another transaction in cycle N+1 are allowed. rvalid for the read in N appears in N+1, concurrent with the new grant.
- Latency:
  - Grant: 0 cycles from req when uncontended.
  - Read data: 1 cycle after grant.
  - Worst-case wait for a requesting master: MAX_BURST cycles.

Test Plan:
- Reset then idle -> all gnt, rvalid, bus_we and bus_re are 0; bus_addr = 0.
- m0 alone writes addr 0x0000_0010, wdata 0xDEADBEEF, mask 0xF -> m0_gnt=1 the same cycle; bus_* mirror m0; RAM word 4 reads back 0xDEADBEEF.
- m1 read of addr 0x10 while m0 idle -> m1_gnt=1 in cycle N, m1_rvalid=1 in N+1 with rdata=0xDEADBEEF; m0_rvalid stays 0.
- Both request continuously, MAX_BURST=4 -> grant pattern m0 x4, m1 x4, m0 x4, ...; no cycle without a grant.
- Both request with MAX_BURST=1 -> strict alternation m0, m1, m0, m1. An idle cycle between grants resets cnt, and the held owner wins next.
- m0 read granted in N, reset asserted in N+1 -> m0_rvalid=0 in N+1 and N+2; owner=0 and cnt=0 after reset.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter for the shared system data bus.
// Bus signals are muxed combinationally from the winner. Read data comes back
// one cycle later, with a valid strobe steered to the master that issued the read.
module bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_mask,
  input  logic        m0_we,
  input  logic        m0_re,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_mask,
  input  logic        m1_we,
  input  logic        m1_re,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata
);

  localparam int              CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  // Arbitration state: last granted master and its run length
  logic          owner_reg;
  logic [CW-1:0] cnt_reg;
  // Outstanding read and the master it belongs to
  logic          rd_pend_reg;
  logic          rd_id_reg;

  // Per-master views, indexed by master number
  logic [1:0]  req_vec;
  logic [1:0]  we_vec;
  logic [1:0]  re_vec;
  logic [31:0] addr_arr  [2];
  logic [31:0] wdata_arr [2];
  logic [3:0]  mask_arr  [2];
  logic [1:0]  gnt_vec;
  logic [1:0]  rvalid_vec;

  logic gnt_any;
  logic winner;

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign re_vec       = {m1_re, m0_re};
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;
  assign mask_arr[0]  = m0_mask;
  assign mask_arr[1]  = m1_mask;

  // Pick the winner: a lone requester wins outright; under contention the
  // owner keeps the bus until its run reaches MAX_BURST. Nothing wins in reset.
  always_comb begin
    gnt_any = 1'b0;
    winner  = 1'b0;
    if (!reset) begin
      if (req_vec == 2'b11) begin
        gnt_any = 1'b1;
        winner  = (cnt_reg < CNT_MAX) ? owner_reg : ~owner_reg;
      end else if (req_vec[0]) begin
        gnt_any = 1'b1;
        winner  = 1'b0;
      end else if (req_vec[1]) begin
        gnt_any = 1'b1;
        winner  = 1'b1;
      end
    end
  end

  // Drive the shared bus from the winner; a write+read request is a write only
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_mask  = '0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    if (gnt_any) begin
      bus_addr  = addr_arr[winner];
      bus_wdata = wdata_arr[winner];
      bus_mask  = mask_arr[winner];
      bus_we    = we_vec[winner];
      bus_re    = re_vec[winner] & ~we_vec[winner];
    end
  end

  // Track ownership and run length, and remember a granted read for one cycle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner_reg   <= 1'b0;
      cnt_reg     <= '0;
      rd_pend_reg <= 1'b0;
      rd_id_reg   <= 1'b0;
    end else begin
      if (gnt_any) begin
        if (winner == owner_reg) begin
          if (cnt_reg < CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end else begin
          owner_reg <= winner;
          cnt_reg   <= CNT_ONE;
        end
      end else begin
        cnt_reg <= '0;
      end
      rd_pend_reg <= bus_re;
      rd_id_reg   <= winner;
    end
  end

  // Grant and read-valid steering; rvalid is masked during reset so a read
  // caught by reset never reports
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign gnt_vec[gi]    = gnt_any & (winner == 1'(gi));
    assign rvalid_vec[gi] = rd_pend_reg & ~reset & (rd_id_reg == 1'(gi));
  end

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign rdata     = bus_rdata;

endmodule
